// File: rtl/am2940_pkg.sv
// Shared opcodes, counter modes and control-register field positions for the
// multi-channel DMA address/word-count generator.
package am2940_pkg;

  localparam logic [2:0] OP_WRCR = 3'b000;
  localparam logic [2:0] OP_RDCR = 3'b001;
  localparam logic [2:0] OP_RDWC = 3'b010;
  localparam logic [2:0] OP_RDAC = 3'b011;
  localparam logic [2:0] OP_REIN = 3'b100;
  localparam logic [2:0] OP_LDAD = 3'b101;
  localparam logic [2:0] OP_LDWC = 3'b110;
  localparam logic [2:0] OP_ARM  = 3'b111;

  localparam logic [1:0] M_DOWN   = 2'b00;
  localparam logic [1:0] M_UP     = 2'b01;
  localparam logic [1:0] M_ADDR   = 2'b10;
  localparam logic [1:0] M_RELOAD = 2'b11;

  localparam int CR_MODE_LO = 0;
  localparam int CR_MODE_HI = 1;
  localparam int CR_DIR     = 2;

endpackage

// File: rtl/am2940_channel.sv
// One DMA channel: address/word registers and counters, control register and
// armed flag. Instructions and transfer steps never target it in the same cycle.
module am2940_channel
  import am2940_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             instr_en,
  input  logic [2:0]       instr,
  input  logic [WIDTH-1:0] di,
  input  logic             step,
  output logic [WIDTH-1:0] ac,
  output logic [WIDTH-1:0] wc,
  output logic [2:0]       cr,
  output logic             armed,
  output logic             terminal,
  output logic             arm_reject
);

  logic [WIDTH-1:0] ar;
  logic [WIDTH-1:0] wr;
  logic [1:0]       mode;
  logic             dir;
  logic             count_down;
  logic [WIDTH-1:0] ac_step;

  assign mode       = cr[CR_MODE_HI:CR_MODE_LO];
  assign dir        = cr[CR_DIR];
  assign count_down = (mode == M_DOWN) || (mode == M_RELOAD);
  assign ac_step    = dir ? (ac - WIDTH'(1)) : (ac + WIDTH'(1));

  always_comb begin
    terminal = 1'b0;
    case (mode)
      M_DOWN, M_RELOAD: terminal = (wc == WIDTH'(1));
      M_UP:             terminal = ((wc + WIDTH'(1)) == wr);
      default:          terminal = (ac == wr);
    endcase
  end

  // An ARM that would start a count-down from zero is refused and reported as done.
  assign arm_reject = instr_en && (instr == OP_ARM) && count_down && (wc == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ar    <= '0;
      ac    <= '0;
      wr    <= '0;
      wc    <= '0;
      cr    <= '0;
      armed <= 1'b0;
    end else if (instr_en) begin
      case (instr)
        OP_WRCR: cr <= di[2:0];
        OP_REIN: begin
          ac    <= ar;
          wc    <= (mode == M_UP) ? '0 : wr;
          armed <= 1'b0;
        end
        OP_LDAD: begin
          ar <= di;
          ac <= di;
        end
        OP_LDWC: begin
          wr <= di;
          wc <= (mode == M_UP) ? '0 : di;
        end
        OP_ARM:  if (!arm_reject) armed <= 1'b1;
        default: ;
      endcase
    end else if (step) begin
      if (terminal && (mode == M_RELOAD)) begin
        ac <= ar;
        wc <= wr;
      end else begin
        ac <= ac_step;
        case (mode)
          M_DOWN, M_RELOAD: wc <= wc - WIDTH'(1);
          M_UP:             wc <= wc + WIDTH'(1);
          default:          ;
        endcase
      end
      if (terminal && (mode != M_RELOAD)) armed <= 1'b0;
    end
  end

endmodule

// File: rtl/am2940_multi_dma.sv
// Multi-channel DMA address generator: NCH channels programmed over a shared
// instruction port, served by a round-robin arbiter with registered outputs.
module am2940_multi_dma
  import am2940_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int CHW   = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             instr_valid,
  input  logic [2:0]       instr,
  input  logic [CHW-1:0]   instr_ch,
  input  logic [WIDTH-1:0] di,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic [NCH-1:0]   req,
  output logic [NCH-1:0]   gnt,
  output logic [WIDTH-1:0] xfer_addr,
  output logic [CHW-1:0]   xfer_ch,
  output logic [NCH-1:0]   armed,
  output logic [NCH-1:0]   done
);

  logic [NCH-1:0]   tgt;
  logic [NCH-1:0]   elig;
  logic [NCH-1:0]   step;
  logic [NCH-1:0]   terminal;
  logic [NCH-1:0]   arm_reject;
  logic [WIDTH-1:0] ac_arr [NCH];
  logic [WIDTH-1:0] wc_arr [NCH];
  logic [2:0]       cr_arr [NCH];
  logic [CHW-1:0]   ptr;
  logic [CHW-1:0]   ptr_next;
  logic [CHW-1:0]   win;
  logic             found;
  logic             is_read;
  logic [WIDTH-1:0] rd_val;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    am2940_channel #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .instr_en  (tgt[g]),
      .instr     (instr),
      .di        (di),
      .step      (step[g]),
      .ac        (ac_arr[g]),
      .wc        (wc_arr[g]),
      .cr        (cr_arr[g]),
      .armed     (armed[g]),
      .terminal  (terminal[g]),
      .arm_reject(arm_reject[g])
    );
  end

  always_comb begin
    tgt = '0;
    for (int i = 0; i < NCH; i++) tgt[i] = instr_valid && (int'(instr_ch) == i);
  end

  // Round robin: first search from the pointer upward, then wrap to the low channels.
  always_comb begin
    elig  = req & armed & ~tgt;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!found && elig[i] && (i >= int'(ptr))) begin
        found = 1'b1;
        win   = CHW'(i);
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!found && elig[i] && (i < int'(ptr))) begin
        found = 1'b1;
        win   = CHW'(i);
      end
    end
    step = '0;
    if (found) step[win] = 1'b1;
    ptr_next = (win == CHW'(NCH - 1)) ? '0 : (win + CHW'(1));
  end

  always_comb begin
    is_read = instr_valid && ((instr == OP_RDCR) || (instr == OP_RDWC) || (instr == OP_RDAC));
    case (instr)
      OP_RDCR: rd_val = WIDTH'(cr_arr[instr_ch]);
      OP_RDWC: rd_val = wc_arr[instr_ch];
      default: rd_val = ac_arr[instr_ch];
    endcase
  end

  // Output register stage: grant, address, done and readback all appear one cycle after sampling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt        <= '0;
      done       <= '0;
      xfer_addr  <= '0;
      xfer_ch    <= '0;
      ptr        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      gnt        <= step;
      done       <= (step & terminal) | arm_reject;
      dout_valid <= is_read;
      if (found) begin
        xfer_addr <= ac_arr[win];
        xfer_ch   <= win;
        ptr       <= ptr_next;
      end
      if (is_read) dout <= rd_val;
    end
  end

endmodule

// File: doc/am2940_multi_dma.md
Name: am2940_multi_dma

Overview:
- Parametrised, multi-channel successor of the team's single-channel DMA address/word-count generator.
- NCH independent channels, each with an address register/counter (AR/AC), a word register/counter (WR/WC) and a control register (CR).
- Programmed through a shared 3-bit instruction port; a round-robin arbiter serves transfer requests and emits one address per cycle.
- Adds address direction per channel, an auto-reload mode, per-channel done pulses and registered readback.

Parameters:
- WIDTH, 8, address/word counter width.
- NCH, 4, number of channels (2..16).
- CHW, $clog2(NCH), channel index width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction strobe, one instruction per cycle
- instr  in  3  opcode
- instr_ch  in  CHW  target channel
- di  in  WIDTH  load data
- dout  out  WIDTH  readback data, registered
- dout_valid  out  1  readback qualifier, 1-cycle pulse
- req  in  NCH  per-channel transfer request, level
- gnt  out  NCH  one-hot grant, registered
- xfer_addr  out  WIDTH  address of the granted transfer (AC before the step), registered
- xfer_ch  out  CHW  granted channel index, registered
- armed  out  NCH  channel enabled for counting
- done  out  NCH  per-channel terminal pulse, 1 cycle

Behaviour:
- Reset (async, reset_n=0): all AR/AC/WR/WC/CR=0, armed=0, gnt=0, done=0, dout=0, dout_valid=0, xfer_addr=0, xfer_ch=0, arbiter pointer=0.
- CR fields: CR[1:0]=mode, CR[2]=dir (0 increment AC, 1 decrement AC).
- Opcodes, taking effect at the clock edge when instr_valid=1, on channel instr_ch:
  - 000 WRCR: CR<=di[2:0].
  - 001 RDCR: dout<={0,CR}.
  - 010 RDWC: dout<=WC.
  - 011 RDAC: dout<=AC.
  - 100 REIN: AC<=AR; WC<=0 if mode 01, else WC<=WR; armed<=0.
  - 101 LDAD: AR<=di, AC<=di.
  - 110 LDWC: WR<=di; WC<=0 if mode 01, else WC<=di.
  - 111 ARM: armed<=1.
- Readback: dout_valid=1 exactly one cycle after a read opcode, otherwise 0; dout holds its last value.
- Arbitration:
  - Eligible set = req & armed & ~(instruction target).
  - The instruction always wins over a same-cycle transfer on the same channel.
  - Round-robin choice starts at the pointer; the pointer moves to winner+1 mod NCH.
  - No eligible channel: gnt=0, and xfer_addr/xfer_ch hold their values.
- Transfer on channel c, all updates at one edge:
  - gnt[c]=1, xfer_addr=AC(old), xfer_ch=c; all three visible 1 cycle after the request is sampled.
  - AC<=AC±1, wrapping modulo 2^WIDTH.
- Word counter and terminal condition per mode, evaluated on the transfer:
  - 00 count-down: WC<=WC-1; terminal when WC(old)==1.
  - 01 count-up: WC<=WC+1; terminal when WC(old)+1==WR (mod 2^WIDTH); WR=0 gives 2^WIDTH transfers.
  - 10 address-stop: WC unchanged; terminal when AC(old)==WR.
  - 11 auto-reload: counts as mode 00; on terminal AC<=AR, WC<=WR, and the channel stays armed.
- On terminal: done[c]=1 for one cycle, registered and coincident with gnt[c]; armed[c]<=0 except in mode 11.
- ARM boundary: ARM in mode 00/11 with WC==0 is rejected. armed stays 0 and done pulses the next cycle.
- Reset asserted mid-transfer: everything clears immediately; no done pulse is issued.

Decomposition:
- am2940_pkg:
  - opcode localparams (WRCR..ARM)
  - mode localparams (M_DOWN, M_UP, M_ADDR, M_RELOAD)
  - CR field indices
- Sub-module am2940_channel, instantiated NCH times via generate:
  - holds AR/AC/WR/WC/CR/armed
  - inputs: instr strobe, step strobe
  - outputs: AC, WC, CR, terminal flag
- Arbiter, readback mux and output registers stay in the top.

Test Plan:
- Ch0: LDAD 0x10, LDWC 3, WRCR 000, ARM, req[0]=1 -> xfer_addr 0x10, 0x11, 0x12 on consecutive cycles; done[0] with the third grant; armed[0]=0; RDWC returns 0.
- Ch1: mode 01, dir 1, AR=0x00, WR=2 -> addresses 0x00, 0xFF (wrap); done[1] on the 2nd grant; RDAC returns 0xFE.
- Ch2: mode 10, AR=0x40, WR=0x42 -> three grants 0x40..0x42, then done; ch3 mode 11 with WR=2, AR=0x80 -> addresses 0x80, 0x81, 0x80, 0x81, done every 2nd grant, stays armed.
- All four channels armed, req=4'b1111 -> gnt cycles 0001, 0010, 0100, 1000, 0001; a RDAC on ch1 in the cycle ch1 would win -> ch1 skipped that cycle, dout_valid the next cycle.
- ARM in mode 00 with WC=0 -> armed stays 0, done pulses once, and no grant follows even with req=1.
- reset_n low mid-sequence -> all outputs 0 asynchronously; after release, RDAC on every channel returns 0.
